// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimation array sequencer.
// The geometry constants describe the 32x32 PE array and its search range.
package me_pkg;

   localparam int PIXEL         = 8;
   localparam int X             = 32;
   localparam int Y             = 32;

   localparam int ROWS          = Y;
   localparam int BEATS_PER_ROW = X / 2;
   localparam int NUM_CB        = 8;
   localparam int SEARCH_ROWS   = 32;
   localparam int ABS_LAT       = 1;

   localparam logic [1:0] REF_HOLD   = 2'd0;
   localparam logic [1:0] REF_SHIFT1 = 2'd1;
   localparam logic [1:0] REF_UP1    = 2'd2;
   localparam logic [1:0] REF_SHIFT8 = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_CURR,
      ST_COMMIT_CURR,
      ST_FILL_REF,
      ST_SWEEP,
      ST_SHIFT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/me_tag_delay.sv
// Delays the {valid, cb, row} tag of each abs sweep step so that it lines up
// with the array's abs_outs; 'pending' flags any tag still in flight.
module me_tag_delay #(
   parameter int LAT   = 1,
   parameter int CB_W  = 3,
   parameter int ROW_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             src_valid,
   input  logic [CB_W-1:0]  src_cb,
   input  logic [ROW_W-1:0] src_row,
   output logic             dly_valid,
   output logic [CB_W-1:0]  dly_cb,
   output logic [ROW_W-1:0] dly_row,
   output logic             pending
);

   localparam int TW = 1 + CB_W + ROW_W;

   logic [TW-1:0] stage [LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) stage[i] <= '0;
      end else begin
         stage[0] <= {src_valid, src_cb, src_row};
         for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
      end
   end

   assign {dly_valid, dly_cb, dly_row} = stage[LAT-1];

   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < LAT; i++) pending = pending | stage[i][TW-1];
   end

endmodule

// File: rtl/me_array_seq.sv
// Sequencer for the 32x32 PE array: loads the current block, pre-fills the
// reference window, then sweeps every CB bank at each vertical search offset.
module me_array_seq
   import me_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] cb_sel,
   input  logic       load_curr,
   input  logic       curr_valid,
   output logic       curr_ready,
   input  logic       ref_valid,
   output logic       ref_ready,
   output logic       in_curr_enable,
   output logic       change_curr,
   output logic [2:0] CB_select,
   output logic [2:0] abs_Control,
   output logic       change_ref,
   output logic [1:0] ref_input_Control,
   output logic       abs_valid,
   output logic [2:0] abs_cb,
   output logic [4:0] abs_row,
   output logic       busy,
   output logic       done
);

   localparam logic [8:0] BEAT_LAST   = 9'(ROWS * BEATS_PER_ROW - 1);
   localparam logic [4:0] ROW_LAST    = 5'(ROWS - 1);
   localparam logic [4:0] OFFSET_LAST = 5'(SEARCH_ROWS - 1);
   localparam logic [2:0] CB_LAST     = 3'(NUM_CB - 1);

   state_t     state, state_nxt;
   logic [8:0] beat_cnt;
   logic [4:0] row_cnt;
   logic [4:0] offset;
   logic [2:0] cb_cnt;
   logic [2:0] cb_reg;
   logic       sweeping;
   logic       tag_pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         beat_cnt <= '0;
         row_cnt  <= '0;
         offset   <= '0;
         cb_cnt   <= '0;
         cb_reg   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: if (start) begin
               cb_reg   <= cb_sel;
               beat_cnt <= '0;
               row_cnt  <= '0;
               offset   <= '0;
               cb_cnt   <= '0;
            end
            ST_LOAD_CURR: if (curr_valid)
               beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + 9'd1;
            ST_FILL_REF: if (ref_valid)
               row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 5'd1;
            ST_SWEEP:
               cb_cnt <= (cb_cnt == CB_LAST) ? '0 : cb_cnt + 3'd1;
            ST_SHIFT: if (ref_valid)
               offset <= offset + 5'd1;
            default: ;
         endcase
      end
   end

   // The array shifts only on a change_ref handshake, so REF_SHIFT1 is
   // presented alongside it and REF_HOLD is kept while waiting for a row.
   always_comb begin
      state_nxt         = state;
      curr_ready        = 1'b0;
      in_curr_enable    = 1'b0;
      change_curr       = 1'b0;
      abs_Control       = '0;
      change_ref        = 1'b0;
      ref_input_Control = REF_HOLD;
      ref_ready         = 1'b0;
      busy              = 1'b1;
      done              = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = load_curr ? ST_LOAD_CURR : ST_FILL_REF;
         end
         ST_LOAD_CURR: begin
            curr_ready     = 1'b1;
            in_curr_enable = curr_valid;
            if (curr_valid && beat_cnt == BEAT_LAST) state_nxt = ST_COMMIT_CURR;
         end
         ST_COMMIT_CURR: begin
            change_curr = 1'b1;
            state_nxt   = ST_FILL_REF;
         end
         ST_FILL_REF: begin
            ref_ready  = 1'b1;
            change_ref = ref_valid;
            if (ref_valid) begin
               ref_input_Control = REF_SHIFT1;
               if (row_cnt == ROW_LAST) state_nxt = ST_SWEEP;
            end
         end
         ST_SWEEP: begin
            abs_Control = cb_cnt;
            if (cb_cnt == CB_LAST)
               state_nxt = (offset == OFFSET_LAST) ? ST_DONE : ST_SHIFT;
         end
         ST_SHIFT: begin
            ref_ready  = 1'b1;
            change_ref = ref_valid;
            if (ref_valid) begin
               ref_input_Control = REF_SHIFT1;
               state_nxt         = ST_SWEEP;
            end
         end
         ST_DONE: begin
            if (!tag_pending) begin
               done      = 1'b1;
               busy      = 1'b0;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign CB_select = (state == ST_IDLE) ? 3'd0 : cb_reg;
   assign sweeping  = (state == ST_SWEEP);

   me_tag_delay #(
      .LAT   (ABS_LAT),
      .CB_W  (3),
      .ROW_W (5)
   ) u_tag_delay (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_valid (sweeping),
      .src_cb    (abs_Control),
      .src_row   (sweeping ? offset : 5'd0),
      .dly_valid (abs_valid),
      .dly_cb    (abs_cb),
      .dly_row   (abs_row),
      .pending   (tag_pending)
   );

endmodule
